vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares a single-port synchronous framebuffer RAM (256x240 NES palette indices) between
//  display scan-out, driven by the VGA timing generator's x_pos/y_pos/valid, and a
//  PPU-side writer. Scales 2x into the 640x480 active area: a 512x480 window plus borders.
//  Generates the per-pixel palette index, a vblank pulse and a frame counter.
// PARAMETERS
//  H_OFF        64     first active x_pos of the 512-px scaled window (left border width)
//  PIX_W        6      palette index width
//  BORDER_INDEX 6'h0F  index output for valid pixels outside the window
//  FB_LINES     240    framebuffer lines; addr >= FB_LINES*256 is out of range
// PORTS
//  clk        in   1      pixel clock
//  reset      in   1      synchronous, active-high
//  x_pos      in   10     timing generator column, 0..799
//  y_pos      in   10     timing generator row, 0..524
//  valid      in   1      timing generator active-area flag
//  wr_valid   in   1      writer request
//  wr_ready   out  1      writer slot available this cycle
//  wr_addr    in   16     {fb_y[7:0], fb_x[7:0]}
//  wr_data    in   PIX_W  index to write
//  wr_drop    out  1      1-cycle pulse: accepted write was out of range and discarded
//  fb_en      out  1      RAM enable
//  fb_we      out  1      RAM write enable
//  fb_addr    out  16     RAM address
//  fb_wdata   out  PIX_W  RAM write data
//  fb_rdata   in   PIX_W  RAM read data, valid the cycle after fb_en && !fb_we
//  pix_valid  out  1      valid delayed 2 cycles
//  pix_index  out  PIX_W  palette index for x_pos/y_pos of 2 cycles earlier
//  vblank     out  1      1-cycle pulse, registered, the cycle after x_pos==0 && y_pos==480 (RUN only)
//  frame_cnt  out  8      frames completed; wraps 255->0
// BEHAVIOUR
//  - Reset: state=SYNC_WAIT; pix_valid=0, pix_index=0, vblank=0, wr_drop=0, frame_cnt=0.
//    Internal pipeline regs are cleared. Mid-frame reset discards in-flight reads.
//  - FSM: SYNC_WAIT -> RUN on the cycle x_pos==0 && y_pos==0. RUN stays RUN. Only reset
//    returns to SYNC_WAIT. In SYNC_WAIT, no display reads are issued, every cycle is a
//    writer slot, and pix_index=0 whenever pix_valid=1.
//  - Window (RUN): win = valid && H_OFF <= x_pos < H_OFF+512. dx = x_pos - H_OFF (10b).
//    A display slot occurs when win && dx[0]==0. The read uses fb_addr={y_pos[8:1], dx[8:1]},
//    fb_en=1, fb_we=0.
//  - Writer: wr_ready = !display_slot (combinational from x_pos/y_pos/valid/state).
//    Accept = wr_valid && wr_ready, and the write goes to the RAM the same cycle:
//    fb_en=1, fb_we=1, fb_addr=wr_addr, fb_wdata=wr_data.
//    If wr_addr >= FB_LINES*256: fb_en=0 and wr_drop=1 on the next cycle.
//    No write buffering. The writer holds its request until accepted.
//  - No slot in use: fb_en=0, fb_we=0. fb_addr and fb_wdata hold their last values.
//  - Pixel pipe (latency 2): stage1 registers win, valid and rd_issued. On rd_issued_d1,
//    hold <= fb_rdata. pix_index is registered as:
//    (win_d1 ? (rd_issued_d1 ? fb_rdata : hold) : BORDER_INDEX) when valid_d1, else 0.
//    The odd-dx pixel repeats the even-dx index (2x horizontal scaling).
//  - Each framebuffer line is read on both y_pos rows 2k and 2k+1 (2x vertical scaling).
//    There is no line buffer.
//  - frame_cnt increments in the same cycle vblank is asserted.
//  - Simultaneous display slot and wr_valid: the display wins and wr_ready=0. The write
//    waits at most 1 cycle.
// TESTING
//  1. Reset, then run from x=0,y=0 -> SYNC_WAIT->RUN at x=0,y=0. First read is at x=64 with
//     fb_addr=0x0000. pix_index is valid 2 cycles later.
//  2. Preload fb[0x0105]=6'h2A; at y=2, x=74/75 -> fb_addr=0x0105 at x=74.
//     pix_index=6'h2A for both pixels, 2 cycles late.
//  3. Hold wr_valid=1 through an active line -> wr_ready alternates 0/1 for x=64..575.
//     Writes land only on odd dx. wr_ready=1 for all of x<64 and x>=576.
//  4. wr_addr=0xF000 accepted -> no RAM write (fb_en=0). wr_drop=1 for one cycle, then 0.
//  5. Valid pixel at x=10 -> pix_index=BORDER_INDEX. At x=700 (valid=0) -> pix_valid=0,
//     pix_index=0.
//  6. Assert reset at y=100 mid-line -> next cycle all outputs are at reset values. No reads
//     until x=0,y=0. vblank pulses once per frame and frame_cnt wraps 255->0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one single-port RAM between 2x-scaled VGA scan-out and a
// PPU-side writer, and produces the per-pixel palette index, a vblank pulse and a frame count.
module vga_fb_arbiter #(
  parameter int               H_OFF        = 64,
  parameter int               PIX_W        = 6,
  parameter logic [PIX_W-1:0] BORDER_INDEX = 'h0F,
  parameter int               FB_LINES     = 240
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x_pos,
  input  logic [9:0]       y_pos,
  input  logic             valid,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [15:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_drop,
  output logic             fb_en,
  output logic             fb_we,
  output logic [15:0]      fb_addr,
  output logic [PIX_W-1:0] fb_wdata,
  input  logic [PIX_W-1:0] fb_rdata,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_index,
  output logic             vblank,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {SYNC_WAIT, RUN} state_e;

  state_e state_q, state_d;

  logic             run, win, disp_slot, accept, in_range, vblank_d;
  logic [8:0]       dx;
  logic [15:0]      rd_addr;
  logic [15:0]      addr_q;
  logic [PIX_W-1:0] wdata_q;

  logic             vld_p1_q, win_p1_q, rd_p1_q, run_p1_q;
  logic [PIX_W-1:0] hold_q;
  logic             pix_valid_q;
  logic [PIX_W-1:0] pix_index_q, pix_index_d;
  logic             vblank_q, wr_drop_q;
  logic [7:0]       frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= SYNC_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == SYNC_WAIT && x_pos == 10'd0 && y_pos == 10'd0) state_d = RUN;
  end

  // Even dx reads the RAM; the odd neighbour reuses that index, leaving its cycle to the writer.
  assign run       = (state_q == RUN);
  assign win       = run && valid && (x_pos >= 10'(H_OFF)) && (x_pos < 10'(H_OFF + 512));
  assign dx        = x_pos[8:0] - 9'(H_OFF);
  assign disp_slot = win && !dx[0];
  assign rd_addr   = {y_pos[8:1], dx[8:1]};
  assign wr_ready  = !disp_slot;
  assign accept    = wr_valid && wr_ready;
  assign in_range  = ({1'b0, wr_addr} < 17'(FB_LINES * 256));
  assign vblank_d  = run && (x_pos == 10'd0) && (y_pos == 10'd480);

  always_comb begin
    fb_en    = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = addr_q;
    fb_wdata = wdata_q;
    if (disp_slot) begin
      fb_en   = 1'b1;
      fb_addr = rd_addr;
    end else if (accept && in_range) begin
      fb_en    = 1'b1;
      fb_we    = 1'b1;
      fb_addr  = wr_addr;
      fb_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (fb_en) begin
      addr_q  <= fb_addr;
      wdata_q <= fb_wdata;
    end
  end

  always_comb begin
    pix_index_d = '0;
    if (vld_p1_q && run_p1_q) pix_index_d = win_p1_q ? (rd_p1_q ? fb_rdata : hold_q) : BORDER_INDEX;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      win_p1_q    <= 1'b0;
      rd_p1_q     <= 1'b0;
      run_p1_q    <= 1'b0;
      hold_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
      vblank_q    <= 1'b0;
      wr_drop_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      // stage 1: slot decision and read issue; RAM data arrives during this stage
      vld_p1_q <= valid;
      win_p1_q <= win;
      rd_p1_q  <= disp_slot;
      run_p1_q <= run;
      if (rd_p1_q) hold_q <= fb_rdata;
      // stage 2: registered pixel output
      pix_valid_q <= vld_p1_q;
      pix_index_q <= pix_index_d;
      vblank_q    <= vblank_d;
      wr_drop_q   <= accept && !in_range;
      if (vblank_d) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_index = pix_index_q;
  assign vblank    = vblank_q;
  assign wr_drop   = wr_drop_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: bench-owned RAM, randomized writer, a frame-level reference
// model of the scaled display, and a scoreboard for the 2-cycle pixel stream.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_pos, y_pos;
  logic        valid, wr_valid, wr_ready, wr_drop;
  logic [15:0] wr_addr, fb_addr;
  logic [5:0]  wr_data, fb_wdata, fb_rdata, pix_index;
  logic        fb_en, fb_we, pix_valid, vblank;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos), .valid(valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop), .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .fb_rdata(fb_rdata), .pix_valid(pix_valid),
    .pix_index(pix_index), .vblank(vblank), .frame_cnt(frame_cnt)
  );

  // External single-port synchronous RAM
  logic [5:0] ram    [0:65535];
  logic [5:0] ref_fb [0:65535];
  always @(posedge clk) begin
    if (fb_en) begin
      if (fb_we) ram[fb_addr] <= fb_wdata;
      else       fb_rdata     <= ram[fb_addr];
    end
  end

  typedef struct {int c; logic [5:0] idx;} pix_t;
  pix_t sbq[$];

  int   checks = 0, failures = 0, cyc = 0;
  bit   started = 0, running = 0, pend = 0, wr_on = 0;
  logic exp_vb = 0, exp_drop = 0;
  logic [7:0]  exp_fc = 0;
  logic [15:0] p_addr = 0;
  logic [5:0]  p_data = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", nm, cyc, got, exp);
    end
  endtask

  // Scoreboard monitor: every presented pixel is matched against the oldest expected one.
  always @(negedge clk) begin
    if (started) begin
      if (pix_valid) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL pix_unexpected cyc=%0d got index=%0h required no valid pixel", cyc, pix_index);
        end else begin
          pix_t e;
          e = sbq.pop_front();
          chk("pix_index", pix_index, e.idx);
          chk("pix_latency", cyc - e.c, 2);
        end
      end else begin
        chk("pix_index_idle", pix_index, 0);
        if (sbq.size() > 0 && sbq[0].c <= cyc - 2) begin
          checks++; failures++;
          $display("FAIL pix_missing cyc=%0d got pix_valid=0 required pixel issued at cyc %0d", cyc, sbq[0].c);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic new_req();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0)      p_addr = 16'hF000 | 16'($urandom_range(0, 4095));
    else if (r < 4)  p_addr = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
    else             p_addr = {8'($urandom_range(0, 239)), 8'($urandom_range(0, 255))};
    if (p_addr == 16'h0105) p_addr = 16'h0106;
    p_data = 6'($urandom_range(0, 63));
    pend   = 1;
  endtask

  task automatic step(input bit rst, input int x, input int y, input bit v);
    int dxi;
    bit inwin, slot, acc, inr;
    pix_t e;
    @(posedge clk); #1;
    if (wr_on && !pend && $urandom_range(0, 3) != 0) new_req();
    reset    = rst;
    x_pos    = 10'(x);
    y_pos    = 10'(y);
    valid    = v;
    wr_valid = pend && wr_on && !rst;
    wr_addr  = p_addr;
    wr_data  = p_data;
    #2;
    chk("vblank", vblank, exp_vb);
    chk("wr_drop", wr_drop, exp_drop);
    chk("frame_cnt", frame_cnt, exp_fc);
    dxi   = x - 64;
    inwin = running && v && x >= 64 && x < 576;
    slot  = inwin && (dxi % 2 == 0);
    acc   = wr_valid && !slot;
    inr   = p_addr < 16'd61440;
    chk("wr_ready", wr_ready, !slot);
    chk("fb_en", fb_en, slot || (acc && inr));
    chk("fb_we", fb_we, acc && inr);
    if (slot) chk("fb_addr_rd", fb_addr, (y / 2) * 256 + dxi / 2);
    if (acc && inr) begin
      chk("fb_addr_wr", fb_addr, p_addr);
      chk("fb_wdata", fb_wdata, p_data);
    end
    if (v) begin
      e.c   = cyc;
      e.idx = !running ? 6'h00 : (inwin ? ref_fb[(y / 2) * 256 + dxi / 2] : 6'h0F);
      sbq.push_back(e);
    end
    if (acc) begin
      if (inr) ref_fb[p_addr] = p_data;
      pend = 0;
    end
    if (rst) begin
      exp_vb = 0; exp_drop = 0; exp_fc = 0; running = 0;
      while (sbq.size() > 0 && sbq[$].c >= cyc - 1) void'(sbq.pop_back());
    end else begin
      exp_vb   = running && x == 0 && y == 480;
      if (exp_vb) exp_fc = exp_fc + 8'd1;
      exp_drop = acc && !inr;
      running  = running || (x == 0 && y == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [5:0] r;
      r = 6'($urandom_range(0, 63));
      ram[i] = r;
      ref_fb[i] = r;
    end
    ram[16'h0105]    = 6'h2A;
    ref_fb[16'h0105] = 6'h2A;
    reset = 1; x_pos = 0; y_pos = 0; valid = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    repeat (3) @(posedge clk);
    started = 1;
    wr_on   = 1;
    for (int i = 0; i < 40; i++)
      step(0, $urandom_range(0, 799), $urandom_range(1, 524), 1'($urandom_range(0, 1)));
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 800; x++) step(0, x, y, x < 640);
    for (int x = 0; x <= 300; x++) step(0, x, 100, x < 640);
    step(1, 301, 100, 1);
    for (int x = 302; x < 362; x++) step(0, x, 100, 1);
    for (int x = 0; x < 800; x++) step(0, x, 0, x < 640);
    wr_on = 0;
    for (int f = 0; f < 257; f++) begin
      step(0, 0, 480, 0);
      step(0, 1, 480, 0);
    end
    repeat (4) step(0, 700, 480, 0);
    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
